// File: rtl/mem_master_pkg.sv
// Shared state type, read-buffer depth and read-credit helper for mem_master.
// The S_INIT state exists only when MEM_MASTER_INIT_EN is defined.
package mem_master_pkg;

    localparam int FIFO_DEPTH = 2;

`ifdef MEM_MASTER_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_INIT  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3
    } state_t;
`endif

    // A new read may only be issued if its word is guaranteed a FIFO slot.
    function automatic logic read_credit_ok(input logic [1:0] fifo_count,
                                            input logic       inflight,
                                            input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        return (occ < 3'(FIFO_DEPTH));
    endfunction

endpackage

// File: rtl/mem_rd_skid.sv
// Two-entry valid/ready FIFO buffering RAM read data; flush empties it synchronously.
module mem_rd_skid
    import mem_master_pkg::*;
#(
    parameter int dataw = 16
) (
    input  logic             CLK,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [dataw-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [dataw-1:0] out_data,
    output logic [1:0]       count
);

    logic [dataw-1:0] mem_r [FIFO_DEPTH];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    // Handshake decode and head-of-queue presentation.
    always_comb begin
        out_valid = (count_r != 2'd0);
        out_data  = mem_r[rd_ptr_r];
        count     = count_r;
        push_s    = in_valid && (count_r != 2'(FIFO_DEPTH));
        pop_s     = out_valid && out_ready;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge CLK) begin
        if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            wr_ptr_r <= wr_ptr_r ^ push_s;
            rd_ptr_r <= rd_ptr_r ^ pop_s;
            count_r  <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Data storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge CLK) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= in_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: rtl/mem_master.sv
// Burst memory master: write bursts pass straight through, read bursts are credit-limited
// into a 2-entry buffer. Define MEM_MASTER_INIT_EN to zero the whole RAM after reset.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int addrw = 10,
    parameter int dataw = 16,
    parameter int lenw  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WRITE,
    input  logic [addrw-1:0] CMD_ADDR,
    input  logic [lenw-1:0]  CMD_LEN,
    input  logic [dataw-1:0] WDATA,
    input  logic             WDATA_VALID,
    output logic             WDATA_READY,
    output logic [dataw-1:0] RDATA,
    output logic             RDATA_VALID,
    input  logic             RDATA_READY,
    output logic             DONE,
    output logic             ENABLE,
    output logic             WRITE,
    output logic [addrw-1:0] ADDR,
    output logic [dataw-1:0] DATAIN,
    input  logic [dataw-1:0] DATAOUT
);

`ifdef MEM_MASTER_INIT_EN
    localparam state_t RESET_STATE = S_INIT;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t           state_r;
    state_t           state_nx_s;
    logic [addrw-1:0] addr_r;
    logic [addrw-1:0] addr_nx_s;
    logic [lenw-1:0]  remain_r;
    logic [lenw-1:0]  remain_nx_s;
    logic             inflight_r;
    logic             issue_s;
    logic             pop_s;
    logic             fifo_valid_s;
    logic [1:0]       fifo_count_s;
    logic [dataw-1:0] fifo_data_s;

    // RAM data lands one cycle after the issue, so the issue flag delayed is the push.
    mem_rd_skid #(.dataw(dataw)) u_skid (
        .CLK       (CLK),
        .flush     (RST),
        .in_valid  (inflight_r),
        .in_data   (DATAOUT),
        .out_valid (fifo_valid_s),
        .out_ready (RDATA_READY),
        .out_data  (fifo_data_s),
        .count     (fifo_count_s)
    );

    // Next-state and RAM/handshake outputs; RST forces every output quiet.
    always_comb begin
        state_nx_s  = state_r;
        addr_nx_s   = addr_r;
        remain_nx_s = remain_r;
        CMD_READY   = 1'b0;
        WDATA_READY = 1'b0;
        ENABLE      = 1'b0;
        WRITE       = 1'b0;
        ADDR        = addr_r;
        DATAIN      = '0;
        DONE        = 1'b0;
        issue_s     = 1'b0;
        RDATA       = fifo_data_s;
        RDATA_VALID = fifo_valid_s;
        pop_s       = fifo_valid_s && RDATA_READY;
        if (RST) begin
            ADDR        = '0;
            RDATA_VALID = 1'b0;
            pop_s       = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    CMD_READY = 1'b1;
                    if (CMD_VALID) begin
                        addr_nx_s   = CMD_ADDR;
                        remain_nx_s = CMD_LEN;
                        state_nx_s  = CMD_WRITE ? S_WR : S_RD;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_WR: begin
                    WDATA_READY = 1'b1;
                    ENABLE      = WDATA_VALID;
                    WRITE       = WDATA_VALID;
                    DATAIN      = WDATA;
                    if (WDATA_VALID) begin
                        addr_nx_s = addr_r + addrw'(1);
                        if (remain_r == '0) begin
                            DONE       = 1'b1;
                            state_nx_s = S_IDLE;
                        end else begin
                            remain_nx_s = remain_r - lenw'(1);
                        end
                    end else begin
                        state_nx_s = S_WR;
                    end
                end
                S_RD: begin
                    issue_s = read_credit_ok(fifo_count_s, inflight_r, pop_s);
                    ENABLE  = issue_s;
                    if (issue_s) begin
                        addr_nx_s = addr_r + addrw'(1);
                        if (remain_r == '0) begin
                            state_nx_s = S_DRAIN;
                        end else begin
                            remain_nx_s = remain_r - lenw'(1);
                        end
                    end else begin
                        state_nx_s = S_RD;
                    end
                end
                S_DRAIN: begin
                    // Burst ends when the final buffered word leaves and nothing is still in the RAM.
                    if (!inflight_r && (fifo_count_s == 2'd1) && pop_s) begin
                        DONE       = 1'b1;
                        state_nx_s = S_IDLE;
                    end else begin
                        state_nx_s = S_DRAIN;
                    end
                end
`ifdef MEM_MASTER_INIT_EN
                S_INIT: begin
                    ENABLE    = 1'b1;
                    WRITE     = 1'b1;
                    addr_nx_s = addr_r + addrw'(1);
                    if (addr_r == '1) begin
                        state_nx_s = S_IDLE;
                    end else begin
                        state_nx_s = S_INIT;
                    end
                end
`endif
                default: begin
                    state_nx_s = S_IDLE;
                end
            endcase
        end
    end

    // State, address, count and in-flight registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= RESET_STATE;
            addr_r     <= '0;
            remain_r   <= '0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            addr_r     <= addr_nx_s;
            remain_r   <= remain_nx_s;
            inflight_r <= issue_s;
        end
    end

endmodule
